s64x7_bus16_bridge: RTL and testbench

- Downstream of the S64X7 core: converts its 64-bit Wishbone-style master port into a 16-bit Wishbone classic master for external SRAM/ROM and I/O.
- Splits each 64-bit access into up to four little-endian halfword beats, skipping halfwords whose byte-select pair is 00, and returns one ack_o per 64-bit access.
- Serves instruction fetches (vpa_i=1) and data stores/loads alike.

---
 rtl/s64x7_bus_pkg.sv | 34 +++
 rtl/s64x7_bus16_bridge_if.sv | 39 +++
 rtl/s64x7_lane_pick.sv | 27 ++
 rtl/s64x7_bus16_bridge.sv | 184 ++++++++++++++++++
 tb/tb_s64x7_bus16_bridge.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/s64x7_bus_pkg.sv
// Shared types and constants for the S64X7 64-to-16-bit bus bridge.
package s64x7_bus_pkg;

  localparam int unsigned LANE_W             = 2;
  localparam int unsigned N_LANES            = 4;
  localparam int unsigned HW_W               = 16;
  localparam int unsigned DW_W               = 64;
  localparam int unsigned SEL_W              = 8;
  localparam int unsigned ADR_W              = 61;
  localparam int unsigned M_ADR_W            = 63;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // Wait counter only needs to hold 0 .. max_cycles-1.
  function automatic int unsigned to_cnt_width(input int unsigned max_cycles);
    return (max_cycles < 3) ? 1 : $clog2(max_cycles);
  endfunction

  localparam int unsigned TO_W_DEF = to_cnt_width(TIMEOUT_CYCLES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             vpa;
    logic [DW_W-1:0]  dat;
  } req_t;

endpackage

// File: rtl/s64x7_bus16_bridge_if.sv
// Core-side 64-bit request port and 16-bit external bus port of the bridge.
interface s64x7_bus16_bridge_if;
  import s64x7_bus_pkg::*;

  logic [ADR_W-1:0]   adr_i;
  logic               cyc_i;
  logic               stb_i;
  logic [SEL_W-1:0]   sel_i;
  logic               we_i;
  logic               vpa_i;
  logic [DW_W-1:0]    dat_i;
  logic               ack_o;
  logic [DW_W-1:0]    dat_o;
  logic               err_o;
  logic [M_ADR_W-1:0] m_adr_o;
  logic               m_cyc_o;
  logic               m_stb_o;
  logic [1:0]         m_sel_o;
  logic               m_we_o;
  logic               m_vpa_o;
  logic [HW_W-1:0]    m_dat_o;
  logic [HW_W-1:0]    m_dat_i;
  logic               m_ack_i;

  // Bridge view: serves the core, drives the external bus.
  modport slave (
    input  adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i, m_dat_i, m_ack_i,
    output ack_o, dat_o, err_o, m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o,
           m_vpa_o, m_dat_o
  );

  // Core + external memory view.
  modport master (
    output adr_i, cyc_i, stb_i, sel_i, we_i, vpa_i, dat_i, m_dat_i, m_ack_i,
    input  ack_o, dat_o, err_o, m_adr_o, m_cyc_o, m_stb_o, m_sel_o, m_we_o,
           m_vpa_o, m_dat_o
  );

endinterface

// File: rtl/s64x7_lane_pick.sv
// Finds the lowest halfword lane with a nonzero byte-select pair at or above
// (INCLUSIVE=1) or strictly above (INCLUSIVE=0) lane k.
module s64x7_lane_pick
  import s64x7_bus_pkg::*;
#(
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [LANE_W-1:0] k,
  output logic [LANE_W-1:0] lane_c,
  output logic              vld_c
);

  // Scan downward so the lowest qualifying lane is written last.
  always_comb begin
    lane_c = '0;
    vld_c  = 1'b0;
    for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
      if ((sel[2*i +: 2] != 2'b00) &&
          (INCLUSIVE ? (i >= int'(k)) : (i > int'(k)))) begin
        lane_c = LANE_W'(i);
        vld_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s64x7_bus16_bridge.sv
// Splits 64-bit core accesses into 16-bit little-endian halfword beats.
// Optional beat timeout enabled by defining S64X7_BRIDGE_TIMEOUT_EN.
module s64x7_bus16_bridge
  import s64x7_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  s64x7_bus16_bridge_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  req_t               req_q, req_d;
  logic [DW_W-1:0]    buf_q, buf_d;

  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DW_W-1:0]    dat_o_q, dat_o_d;
  logic [M_ADR_W-1:0] m_adr_q, m_adr_d;
  logic               m_cyc_q, m_cyc_d;
  logic               m_stb_q, m_stb_d;
  logic [1:0]         m_sel_q, m_sel_d;
  logic               m_we_q, m_we_d;
  logic               m_vpa_q, m_vpa_d;
  logic [HW_W-1:0]    m_dat_q, m_dat_d;

  logic [LANE_W-1:0]  first_lane_c, next_lane_c;
  logic               first_vld_c, next_vld_c;
  logic               to_hit_c;

  s64x7_lane_pick #(.INCLUSIVE(1'b1)) u_first_pick (
    .sel    (bus.sel_i),
    .k      (LANE_W'(0)),
    .lane_c (first_lane_c),
    .vld_c  (first_vld_c)
  );

  s64x7_lane_pick #(.INCLUSIVE(1'b0)) u_next_pick (
    .sel    (req_q.sel),
    .k      (lane_q),
    .lane_c (next_lane_c),
    .vld_c  (next_vld_c)
  );

`ifdef S64X7_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = to_cnt_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wait_q, wait_d;

  assign to_hit_c = (state_q == ST_BEAT) && bus.cyc_i && !bus.m_ack_i &&
                    (wait_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts unacknowledged cycles of the current beat; restarts on every new beat.
  always_comb begin
    wait_d = '0;
    if ((state_q == ST_BEAT) && (state_d == ST_BEAT) && !bus.m_ack_i)
      wait_d = wait_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) wait_q <= '0;
    else         wait_q <= wait_d;
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // State register plus all registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      req_q   <= '0;
      buf_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_o_q <= '0;
      m_adr_q <= '0;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_sel_q <= 2'b00;
      m_we_q  <= 1'b0;
      m_vpa_q <= 1'b0;
      m_dat_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_o_q <= dat_o_d;
      m_adr_q <= m_adr_d;
      m_cyc_q <= m_cyc_d;
      m_stb_q <= m_stb_d;
      m_sel_q <= m_sel_d;
      m_we_q  <= m_we_d;
      m_vpa_q <= m_vpa_d;
      m_dat_q <= m_dat_d;
    end
  end

  // Next state, lane walk, request latch and read-buffer fill.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    req_d   = req_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          req_d = '{adr: bus.adr_i, sel: bus.sel_i, we: bus.we_i,
                    vpa: bus.vpa_i, dat: bus.dat_i};
          buf_d = '0;
          if (first_vld_c) begin
            state_d = ST_BEAT;
            lane_d  = first_lane_c;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_BEAT: begin
        // Abort wins over a coincident beat acknowledge.
        if (!bus.cyc_i) begin
          state_d = ST_IDLE;
        end else if (bus.m_ack_i) begin
          if (!req_q.we) buf_d[{lane_q, 4'b0000} +: HW_W] = bus.m_dat_i;
          if (next_vld_c) lane_d  = next_lane_c;
          else            state_d = ST_DONE;
        end else if (to_hit_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the cycle following this edge.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_o_d = '0;
    m_adr_d = '0;
    m_cyc_d = 1'b0;
    m_stb_d = 1'b0;
    m_sel_d = 2'b00;
    m_we_d  = 1'b0;
    m_vpa_d = 1'b0;
    m_dat_d = '0;
    if (state_d == ST_DONE) begin
      ack_d   = 1'b1;
      err_d   = to_hit_c;
      dat_o_d = buf_d;
    end
    if (state_d == ST_BEAT) begin
      m_cyc_d = 1'b1;
      m_stb_d = 1'b1;
      m_adr_d = {req_d.adr, lane_d};
      m_sel_d = req_d.sel[{lane_d, 1'b0} +: 2];
      m_we_d  = req_d.we;
      m_vpa_d = req_d.vpa;
      m_dat_d = req_d.dat[{lane_d, 4'b0000} +: HW_W];
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.dat_o   = dat_o_q;
  assign bus.m_adr_o = m_adr_q;
  assign bus.m_cyc_o = m_cyc_q;
  assign bus.m_stb_o = m_stb_q;
  assign bus.m_sel_o = m_sel_q;
  assign bus.m_we_o  = m_we_q;
  assign bus.m_vpa_o = m_vpa_q;
  assign bus.m_dat_o = m_dat_q;

endmodule

// File: tb/tb_s64x7_bus16_bridge.sv
// Directed self-checking bench for s64x7_bus16_bridge; core and 16-bit slave
// are modelled procedurally, beats are recorded and compared to hand values.
module tb_s64x7_bus16_bridge;
  import s64x7_bus_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  s64x7_bus16_bridge_if bus ();

`ifdef S64X7_BRIDGE_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  s64x7_bus16_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] b_addr [4];
  logic [1:0]  b_sel  [4];
  logic [15:0] b_dat  [4];
  logic        b_we   [4];
  logic        b_vpa  [4];
  logic [15:0] rd_hw  [4];
  int          nbeats;
  int          ack_cyc;
  int          cyc_hi;
  logic [63:0] r_dat;
  logic        r_err;
  logic        ack_next;
  logic        cyc_after_abort;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One core access; slave acks after 'waits' wait states unless never_ack.
  task automatic run_access(input logic [63:0] baddr, input logic [7:0] sel,
                            input logic we, input logic vpa, input logic [63:0] wdat,
                            input int waits, input int abort_beat, input bit never_ack);
    int  wcnt;
    int  n;
    int  post;
    bit  aborted;
    wcnt = 0; n = 0; post = 0; aborted = 1'b0;
    nbeats = 0; ack_cyc = -1; cyc_hi = 0; r_dat = '0; r_err = 1'b0;
    ack_next = 1'b0; cyc_after_abort = 1'b1;
    bus.adr_i = baddr[63:3];
    bus.sel_i = sel;
    bus.we_i  = we;
    bus.vpa_i = vpa;
    bus.dat_i = wdat;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    while (n < 40) begin
      @(posedge clk_i); #1;
      n++;
      bus.m_ack_i = 1'b0;
      bus.m_dat_i = 16'hDEAD;
      if (aborted) begin
        post++;
        if (post == 1) cyc_after_abort = bus.m_cyc_o;
        if (bus.ack_o) ack_cyc = n;
        if (post == 3) break;
        continue;
      end
      if (bus.ack_o) begin
        ack_cyc = n;
        r_dat   = bus.dat_o;
        r_err   = bus.err_o;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        @(posedge clk_i); #1;
        ack_next = bus.ack_o;
        break;
      end
      if (bus.m_cyc_o && bus.m_stb_o) begin
        cyc_hi++;
        if (wcnt == 0) begin
          if (nbeats < 4) begin
            b_addr[nbeats] = {bus.m_adr_o, 1'b0};
            b_sel[nbeats]  = bus.m_sel_o;
            b_dat[nbeats]  = bus.m_dat_o;
            b_we[nbeats]   = bus.m_we_o;
            b_vpa[nbeats]  = bus.m_vpa_o;
          end
          nbeats++;
        end
        if (abort_beat == nbeats - 1) begin
          bus.cyc_i = 1'b0;
          bus.stb_i = 1'b0;
          aborted   = 1'b1;
        end else if (!never_ack && wcnt == waits) begin
          bus.m_ack_i = 1'b1;
          bus.m_dat_i = rd_hw[2'(nbeats - 1)];
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    bus.cyc_i   = 1'b0;
    bus.stb_i   = 1'b0;
    bus.m_ack_i = 1'b0;
  endtask

  initial begin
    reset_i     = 1'b1;
    bus.adr_i   = '0;
    bus.cyc_i   = 1'b0;
    bus.stb_i   = 1'b0;
    bus.sel_i   = '0;
    bus.we_i    = 1'b0;
    bus.vpa_i   = 1'b0;
    bus.dat_i   = '0;
    bus.m_dat_i = '0;
    bus.m_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) rd_hw[i] = '0;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ack",   64'(bus.ack_o),   64'(0));
    check("rst_cyc",   64'(bus.m_cyc_o), 64'(0));
    check("rst_sel",   64'(bus.m_sel_o), 64'(0));
    check("rst_err",   64'(bus.err_o),   64'(0));
    check("rst_adr",   64'(bus.m_adr_o), 64'(0));
    check("rst_dat_o", bus.dat_o,        64'(0));
    reset_i = 1'b0;

    // Single byte store
    run_access(64'h1111_1110, 8'h02, 1'b1, 1'b0, 64'h4141_4141_4141_4141, 0, -1, 1'b0);
    check("sbm_beats", 64'(nbeats),    64'(1));
    check("sbm_addr",  b_addr[0],      64'h1111_1110);
    check("sbm_sel",   64'(b_sel[0]),  64'(2'b10));
    check("sbm_dat",   64'(b_dat[0]),  64'h4141);
    check("sbm_we",    64'(b_we[0]),   64'(1));
    check("sbm_ackc",  64'(ack_cyc),   64'(2));
    check("sbm_ack1",  64'(ack_next),  64'(0));
    check("sbm_err",   64'(r_err),     64'(0));

    // Upper word store
    run_access(64'h3333_3330, 8'hF0, 1'b1, 1'b0, 64'h0000_0041_0000_0041, 0, -1, 1'b0);
    check("swm_beats", 64'(nbeats),   64'(2));
    check("swm_addr0", b_addr[0],     64'h3333_3334);
    check("swm_dat0",  64'(b_dat[0]), 64'h0041);
    check("swm_sel0",  64'(b_sel[0]), 64'(2'b11));
    check("swm_addr1", b_addr[1],     64'h3333_3336);
    check("swm_dat1",  64'(b_dat[1]), 64'h0000);
    check("swm_sel1",  64'(b_sel[1]), 64'(2'b11));
    check("swm_ackc",  64'(ack_cyc),  64'(3));

    // Instruction fetch, one wait state per beat
    rd_hw[0] = 16'h1111; rd_hw[1] = 16'h2222; rd_hw[2] = 16'h3333; rd_hw[3] = 16'h4444;
    run_access(64'hE000_0000_0000_0000, 8'hFF, 1'b0, 1'b1, 64'h0, 1, -1, 1'b0);
    check("ifx_beats", 64'(nbeats),   64'(4));
    check("ifx_vpa",   64'(b_vpa[0]), 64'(1));
    check("ifx_we",    64'(b_we[0]),  64'(0));
    check("ifx_addr0", b_addr[0],     64'hE000_0000_0000_0000);
    check("ifx_addr3", b_addr[3],     64'hE000_0000_0000_0006);
    check("ifx_dat",   r_dat,         64'h4444_3333_2222_1111);
    check("ifx_ackc",  64'(ack_cyc),  64'(9));

    // Sparse select read
    rd_hw[0] = 16'hAAAA; rd_hw[1] = 16'hBBBB;
    run_access(64'h0000_0000_0000_1000, 8'hC3, 1'b0, 1'b0, 64'h0, 0, -1, 1'b0);
    check("spr_beats", 64'(nbeats),   64'(2));
    check("spr_addr0", b_addr[0],     64'h1000);
    check("spr_addr1", b_addr[1],     64'h1006);
    check("spr_sel1",  64'(b_sel[1]), 64'(2'b11));
    check("spr_dat",   r_dat,         64'hBBBB_0000_0000_AAAA);
    check("spr_ackc",  64'(ack_cyc),  64'(3));

    // Same access aborted during the lane-3 beat
    run_access(64'h0000_0000_0000_1000, 8'hC3, 1'b0, 1'b0, 64'h0, 0, 1, 1'b0);
    check("abt_beats", 64'(nbeats),          64'(2));
    check("abt_cyc",   64'(cyc_after_abort), 64'(0));
    check("abt_noack", 64'(ack_cyc),         64'(-1));

    // Empty select: immediate completion with zero data
    run_access(64'h0000_0000_0000_2000, 8'h00, 1'b0, 1'b0, 64'h0, 0, -1, 1'b0);
    check("sel0_beats", 64'(nbeats),  64'(0));
    check("sel0_ackc",  64'(ack_cyc), 64'(1));
    check("sel0_dat",   r_dat,        64'(0));

    // Reset while a beat is pending
    bus.adr_i = 61'h200; bus.sel_i = 8'hFF; bus.we_i = 1'b0; bus.vpa_i = 1'b0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk_i); #1;
    check("mrst_beat", 64'(bus.m_cyc_o), 64'(1));
    reset_i = 1'b1; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    @(posedge clk_i); #1;
    check("mrst_cyc", 64'(bus.m_cyc_o), 64'(0));
    check("mrst_ack", 64'(bus.ack_o),   64'(0));
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("mrst_idle", 64'(bus.ack_o), 64'(0));

`ifdef S64X7_BRIDGE_TIMEOUT_EN
    run_access(64'h0000_0000_0000_3000, 8'h0C, 1'b0, 1'b0, 64'h0, 0, -1, 1'b1);
    check("to_cychi", 64'(cyc_hi),   64'(4));
    check("to_ackc",  64'(ack_cyc),  64'(5));
    check("to_err",   64'(r_err),    64'(1));
    check("to_addr",  b_addr[0],     64'h3002);
    check("to_ack1",  64'(ack_next), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
